data_block_padder: RTL and testbench

DATA_BLOCK_PADDER -- requirements
Module: data_block_padder

---
 rtl/data_block_padder.sv | 148 ++++++++++++++
 tb/tb_data_block_padder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_block_padder.sv
// Byte-masking and 0x80 padding of a 64-bit message stream into a small block FIFO.
// A full final beat is followed by a pad-only block; the FSM holds off new beats until the final block drains.
module data_block_padder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_data_valid,
    output logic                     o_data_ready,
    input  logic [63:0]              i_data,
    input  logic [3:0]               i_data_bytes,
    input  logic                     i_data_last,
    output logic [63:0]              o_block,
    output logic                     o_block_valid,
    output logic                     o_block_last,
    input  logic                     i_block_consume,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_protocol_error
);

    localparam int unsigned     AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE   = 1;
    localparam logic [AW:0]     CNT_ONE   = 1;
    localparam logic [AW:0]     CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [63:0]     PAD_BLOCK = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_PAD,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic [63:0]     mem_data_q [DEPTH];
    logic [DEPTH-1:0] mem_last_q;

    logic [3:0]      n_eff;
    logic [63:0]     beat_block;
    logic            accept;
    logic            pop;
    logic            push;
    logic [63:0]     push_data;
    logic            push_last;
    logic            head_last;

    assign o_data_ready = (state_q == S_ACCEPT) && (count_q < CNT_FULL);
    assign accept       = i_data_valid && o_data_ready;
    assign pop          = i_block_consume && (count_q != '0);
    assign head_last    = mem_last_q[rd_ptr_q];

    // Byte counts above 8 are clamped; the pad byte lands at index n only on a short final beat.
    always_comb begin
        n_eff      = (i_data_bytes > 4'd8) ? 4'd8 : i_data_bytes;
        beat_block = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (4'(b) < n_eff) begin
                beat_block[63-8*b -: 8] = i_data[63-8*b -: 8];
            end else if ((4'(b) == n_eff) && i_data_last) begin
                beat_block[63-8*b -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        push      = 1'b0;
        push_data = beat_block;
        push_last = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                if (accept) begin
                    push = 1'b1;
                    if ((!i_data_last && (i_data_bytes != 4'd8)) || (i_data_bytes > 4'd8)) begin
                        err_d = 1'b1;
                    end
                    if (i_data_last) begin
                        if (n_eff == 4'd8) begin
                            state_d = S_PAD;
                        end else begin
                            push_last = 1'b1;
                            state_d   = S_DRAIN;
                        end
                    end
                end
            end
            S_PAD: begin
                if (count_q < CNT_FULL) begin
                    push      = 1'b1;
                    push_data = PAD_BLOCK;
                    push_last = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_ACCEPT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; every read is gated by occupancy.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

    assign o_block_valid    = (count_q != '0);
    assign o_block          = o_block_valid ? mem_data_q[rd_ptr_q] : '0;
    assign o_block_last     = o_block_valid && head_last;
    assign o_count          = count_q;
    assign o_protocol_error = err_q;

endmodule

// File: tb/tb_data_block_padder.sv
// Directed bench for data_block_padder: padding table plus hand-written multi-cycle sequences.
module tb_data_block_padder;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [63:0] i_data;
    logic [3:0]  i_data_bytes;
    logic        i_data_last;
    logic [63:0] o_block;
    logic        o_block_valid;
    logic        o_block_last;
    logic        i_block_consume;
    logic [1:0]  o_count;
    logic        o_protocol_error;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [8];

    data_block_padder #(.DEPTH(2)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_data_valid    (i_data_valid),
        .o_data_ready    (o_data_ready),
        .i_data          (i_data),
        .i_data_bytes    (i_data_bytes),
        .i_data_last     (i_data_last),
        .o_block         (o_block),
        .o_block_valid   (o_block_valid),
        .o_block_last    (o_block_last),
        .i_block_consume (i_block_consume),
        .o_count         (o_count),
        .o_protocol_error(o_protocol_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [3:0] n, input logic last);
        i_data_valid = 1'b1;
        i_data       = d;
        i_data_bytes = n;
        i_data_last  = last;
    endtask

    initial begin
        vecs[0] = '{64'h0102_0304_0500_0000, 4'd5, 64'h0102_0304_0580_0000};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 64'h8000_0000_0000_0000};
        vecs[2] = '{64'hAABB_CCDD_EEFF_0011, 4'd1, 64'hAA80_0000_0000_0000};
        vecs[3] = '{64'h0000_0000_0000_0000, 4'd2, 64'h0000_8000_0000_0000};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 4'd3, 64'h1234_5680_0000_0000};
        vecs[5] = '{64'hDEAD_BEEF_CAFE_BABE, 4'd4, 64'hDEAD_BEEF_8000_0000};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 4'd6, 64'h0123_4567_89AB_8000};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 64'hFFFF_FFFF_FFFF_FF80};

        i_reset = 1'b1; i_data_valid = 1'b0; i_data = '0; i_data_bytes = '0;
        i_data_last = 1'b0; i_block_consume = 1'b0;
        tick();
        i_reset = 1'b0;
        check("rst_count", o_count, 0);
        check("rst_valid", o_block_valid, 0);
        check("rst_block", o_block, 0);
        check("rst_last", o_block_last, 0);
        check("rst_err", o_protocol_error, 0);
        check("rst_ready", o_data_ready, 1);

        // Single short final beats: padded block, drain hold, release on pop.
        for (int i = 0; i < 8; i++) begin
            check("vec_ready_in", o_data_ready, 1);
            beat(vecs[i].data, vecs[i].bytes, 1'b1);
            tick();
            i_data_valid = 1'b0;
            check("vec_block", o_block, vecs[i].exp);
            check("vec_last", o_block_last, 1);
            check("vec_count", o_count, 1);
            check("vec_ready_drain", o_data_ready, 0);
            tick();
            check("vec_ready_hold", o_data_ready, 0);
            i_block_consume = 1'b1;
            tick();
            i_block_consume = 1'b0;
            check("vec_pop_valid", o_block_valid, 0);
            check("vec_pop_block", o_block, 0);
            check("vec_pop_ready", o_data_ready, 1);
        end

        // Full final beat: data block then pad-only block.
        beat(64'h1111_2222_3333_4444, 4'd8, 1'b1);
        tick();
        i_data_valid = 1'b0;
        check("n8_block", o_block, 64'h1111_2222_3333_4444);
        check("n8_last", o_block_last, 0);
        check("n8_ready_pad", o_data_ready, 0);
        tick();
        check("n8_count2", o_count, 2);
        check("n8_ready_drain", o_data_ready, 0);
        i_block_consume = 1'b1;
        tick();
        check("n8_pad_block", o_block, 64'h8000_0000_0000_0000);
        check("n8_pad_last", o_block_last, 1);
        check("n8_ready_mid", o_data_ready, 0);
        tick();
        i_block_consume = 1'b0;
        check("n8_count0", o_count, 0);
        check("n8_ready_end", o_data_ready, 1);

        // Consume on empty FIFO is ignored.
        i_block_consume = 1'b1;
        tick();
        i_block_consume = 1'b0;
        check("underflow_count", o_count, 0);
        check("underflow_valid", o_block_valid, 0);

        // Back-pressure and ordering with three non-last beats, then push+pop together.
        beat(64'hAAAA_0000_0000_000A, 4'd8, 1'b0);
        tick();
        check("bp_count1", o_count, 1);
        check("bp_ready1", o_data_ready, 1);
        beat(64'hBBBB_0000_0000_000B, 4'd8, 1'b0);
        tick();
        check("bp_count2", o_count, 2);
        check("bp_ready_full", o_data_ready, 0);
        beat(64'hCCCC_0000_0000_000C, 4'd8, 1'b0);
        tick();
        check("bp_hold_count", o_count, 2);
        check("bp_head_a", o_block, 64'hAAAA_0000_0000_000A);
        i_block_consume = 1'b1;
        tick();
        i_block_consume = 1'b0;
        check("bp_pop_count", o_count, 1);
        check("bp_head_b", o_block, 64'hBBBB_0000_0000_000B);
        check("bp_ready_again", o_data_ready, 1);
        tick();
        i_data_valid = 1'b0;
        check("bp_c_count", o_count, 2);
        i_block_consume = 1'b1;
        tick();
        check("bp_head_c", o_block, 64'hCCCC_0000_0000_000C);
        check("bp_c_last", o_block_last, 0);
        beat(64'hDDDD_0000_0000_000D, 4'd8, 1'b0);
        tick();
        i_data_valid = 1'b0;
        check("pp_count", o_count, 1);
        check("pp_head_d", o_block, 64'hDDDD_0000_0000_000D);
        tick();
        i_block_consume = 1'b0;
        check("pp_empty", o_count, 0);
        check("bp_err_clear", o_protocol_error, 0);

        // Short non-last beat raises the sticky error.
        beat(64'h1234_5678_90AB_CDEF, 4'd3, 1'b0);
        tick();
        i_data_valid = 1'b0;
        check("err_block", o_block, 64'h1234_5600_0000_0000);
        check("err_set", o_protocol_error, 1);
        check("err_ready", o_data_ready, 1);
        i_block_consume = 1'b1;
        tick();
        i_block_consume = 1'b0;
        beat(64'h0102_0304_0500_0000, 4'd5, 1'b1);
        tick();
        i_data_valid = 1'b0;
        check("err_msg_block", o_block, 64'h0102_0304_0580_0000);
        i_block_consume = 1'b1;
        tick();
        i_block_consume = 1'b0;
        check("err_sticky", o_protocol_error, 1);

        // Oversized final beat behaves as a full beat followed by a pad block.
        beat(64'hAAAA_BBBB_CCCC_DDDD, 4'd9, 1'b1);
        tick();
        i_data_valid = 1'b0;
        check("big_block", o_block, 64'hAAAA_BBBB_CCCC_DDDD);
        check("big_last", o_block_last, 0);
        tick();
        check("big_count2", o_count, 2);
        i_block_consume = 1'b1;
        tick();
        check("big_pad", o_block, 64'h8000_0000_0000_0000);
        check("big_pad_last", o_block_last, 1);
        tick();
        i_block_consume = 1'b0;
        check("big_ready", o_data_ready, 1);

        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("err_cleared", o_protocol_error, 0);

        // Reset while a pad block is pending with a full FIFO.
        beat(64'h5555_5555_5555_5555, 4'd8, 1'b0);
        tick();
        beat(64'h6666_6666_6666_6666, 4'd8, 1'b1);
        tick();
        i_data_valid = 1'b0;
        check("spad_count", o_count, 2);
        check("spad_ready", o_data_ready, 0);
        check("spad_head", o_block, 64'h5555_5555_5555_5555);
        tick();
        check("spad_hold", o_count, 2);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("spad_rst_count", o_count, 0);
        check("spad_rst_valid", o_block_valid, 0);
        check("spad_rst_block", o_block, 0);
        check("spad_rst_ready", o_data_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spad_no_pad", o_block_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
